// File: rtl/pma_region_table.sv
// Runtime-programmable physical-memory-attribute table: NrRegions writable
// base/length/attr entries and NrLookupPorts registered attribute lookups.
module pma_region_table #(
  parameter int unsigned NrRegions     = 4,
  parameter int unsigned AddrWidth     = 64,
  parameter int unsigned NrLookupPorts = 2,
  parameter logic [NrRegions*AddrWidth-1:0] RstBase   = '0,
  parameter logic [NrRegions*AddrWidth-1:0] RstLength = '0,
  parameter logic [NrRegions*5-1:0]         RstAttr   = '0,
  localparam int unsigned IdxWidth = (NrRegions > 1) ? $clog2(NrRegions) : 1
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  // configuration port
  input  logic                               cfg_req_i,
  input  logic                               cfg_we_i,
  input  logic [IdxWidth-1:0]                cfg_idx_i,
  input  logic [1:0]                         cfg_field_i,
  input  logic [AddrWidth-1:0]               cfg_wdata_i,
  output logic                               cfg_gnt_o,
  output logic                               cfg_rvalid_o,
  output logic [AddrWidth-1:0]               cfg_rdata_o,
  output logic                               cfg_err_o,
  output logic                               cfg_change_o,
  // lookup ports
  input  logic [NrLookupPorts-1:0]           lkp_valid_i,
  input  logic [NrLookupPorts*AddrWidth-1:0] lkp_addr_i,
  output logic [NrLookupPorts-1:0]           lkp_valid_o,
  output logic [NrLookupPorts-1:0]           lkp_hit_o,
  output logic [NrLookupPorts-1:0]           lkp_exec_o,
  output logic [NrLookupPorts-1:0]           lkp_cached_o,
  output logic [NrLookupPorts-1:0]           lkp_nonidem_o
);

  localparam int unsigned AttrWidth = 5;

  localparam logic [1:0] FieldBase   = 2'd0;
  localparam logic [1:0] FieldLength = 2'd1;
  localparam logic [1:0] FieldAttr   = 2'd2;
  localparam logic [1:0] FieldRsvd   = 2'd3;

  typedef struct packed {
    logic lock;
    logic valid;
    logic nonidem;
    logic cached;
    logic exec;
  } attr_t;

  logic [AddrWidth-1:0] base_q [NrRegions];
  logic [AddrWidth-1:0] len_q  [NrRegions];
  attr_t                attr_q [NrRegions];

  logic                 idx_ok;
  logic                 field_ok;
  logic                 sel_locked;
  logic                 acc_err;
  logic                 wr_en;
  logic [AddrWidth-1:0] rd_val;

  logic [NrRegions-1:0]     match [NrLookupPorts];
  logic [NrLookupPorts-1:0] hit_n;
  logic [NrLookupPorts-1:0] exec_n;
  logic [NrLookupPorts-1:0] cached_n;
  logic [NrLookupPorts-1:0] nonidem_n;

  // Range check in AddrWidth+1 bits so a region near the top never wraps to 0.
  function automatic logic region_match(input logic [AddrWidth-1:0] addr,
                                        input logic [AddrWidth-1:0] base,
                                        input logic [AddrWidth-1:0] len,
                                        input logic                 valid);
    logic [AddrWidth:0] diff;
    diff = {1'b0, addr} - {1'b0, base};
    return valid && (len != '0) && (addr >= base) && (diff < {1'b0, len});
  endfunction

  assign cfg_gnt_o = cfg_req_i;

  // Config access decode: legality, lock state and pre-edge read value.
  always_comb begin
    idx_ok     = ({1'b0, cfg_idx_i} < (IdxWidth+1)'(NrRegions));
    field_ok   = (cfg_field_i != FieldRsvd);
    sel_locked = 1'b0;
    rd_val     = '0;
    for (int unsigned i = 0; i < NrRegions; i++) begin
      if (cfg_idx_i == IdxWidth'(i)) begin
        sel_locked = attr_q[i].lock;
        case (cfg_field_i)
          FieldBase:   rd_val = base_q[i];
          FieldLength: rd_val = len_q[i];
          FieldAttr:   rd_val = AddrWidth'(attr_q[i]);
          default:     rd_val = '0;
        endcase
      end
    end
    acc_err = !idx_ok || !field_ok || (cfg_we_i && sel_locked);
    wr_en   = cfg_req_i && cfg_we_i && !acc_err;
  end

  // Region table storage.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < NrRegions; i++) begin
        base_q[i] <= RstBase[i*AddrWidth +: AddrWidth];
        len_q[i]  <= RstLength[i*AddrWidth +: AddrWidth];
        attr_q[i] <= attr_t'(RstAttr[i*AttrWidth +: AttrWidth]);
      end
    end else if (wr_en) begin
      for (int unsigned i = 0; i < NrRegions; i++) begin
        if (cfg_idx_i == IdxWidth'(i)) begin
          case (cfg_field_i)
            FieldBase:   base_q[i] <= cfg_wdata_i;
            FieldLength: len_q[i]  <= cfg_wdata_i;
            FieldAttr:   attr_q[i] <= attr_t'(cfg_wdata_i[AttrWidth-1:0]);
            default:     ;
          endcase
        end
      end
    end
  end

  // Config response, one cycle after grant; reset drops any pending response.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cfg_rvalid_o <= 1'b0;
      cfg_err_o    <= 1'b0;
      cfg_rdata_o  <= '0;
      cfg_change_o <= 1'b0;
    end else begin
      cfg_rvalid_o <= cfg_req_i;
      cfg_err_o    <= cfg_req_i && acc_err;
      cfg_rdata_o  <= (cfg_req_i && !cfg_we_i && !acc_err) ? rd_val : '0;
      cfg_change_o <= wr_en;
    end
  end

  // Parallel match of every region against every port address.
  always_comb begin
    for (int unsigned p = 0; p < NrLookupPorts; p++) begin
      match[p] = '0;
      for (int unsigned i = 0; i < NrRegions; i++) begin
        match[p][i] = region_match(lkp_addr_i[p*AddrWidth +: AddrWidth],
                                   base_q[i], len_q[i], attr_q[i].valid);
      end
    end
  end

  // Priority select: lowest matching index wins, miss yields the safe default.
  always_comb begin
    hit_n     = '0;
    exec_n    = '0;
    cached_n  = '0;
    nonidem_n = '1;
    for (int unsigned p = 0; p < NrLookupPorts; p++) begin
      for (int unsigned i = 0; i < NrRegions; i++) begin
        if (match[p][i] && !hit_n[p]) begin
          hit_n[p]     = 1'b1;
          exec_n[p]    = attr_q[i].exec;
          cached_n[p]  = attr_q[i].cached;
          nonidem_n[p] = attr_q[i].nonidem;
        end
      end
    end
  end

  // Lookup response registers; idle ports hold their last attributes.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lkp_valid_o   <= '0;
      lkp_hit_o     <= '0;
      lkp_exec_o    <= '0;
      lkp_cached_o  <= '0;
      lkp_nonidem_o <= '1;
    end else begin
      lkp_valid_o <= lkp_valid_i;
      for (int unsigned p = 0; p < NrLookupPorts; p++) begin
        if (lkp_valid_i[p]) begin
          lkp_hit_o[p]     <= hit_n[p];
          lkp_exec_o[p]    <= exec_n[p];
          lkp_cached_o[p]  <= cached_n[p];
          lkp_nonidem_o[p] <= nonidem_n[p];
        end
      end
    end
  end

endmodule

// File: tb/tb_pma_region_table.sv
// Directed bench for pma_region_table: reset image, range edges, write/lookup
// ordering, locking, priority, illegal accesses and dual-port lookups.
module tb_pma_region_table;

  localparam int unsigned NR = 3;
  localparam int unsigned AW = 64;
  localparam int unsigned NP = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic           cfg_req;
  logic           cfg_we;
  logic [1:0]     cfg_idx;
  logic [1:0]     cfg_field;
  logic [AW-1:0]  cfg_wdata;
  logic           cfg_gnt;
  logic           cfg_rvalid;
  logic [AW-1:0]  cfg_rdata;
  logic           cfg_err;
  logic           cfg_change;
  logic [NP-1:0]    lkp_valid;
  logic [NP*AW-1:0] lkp_addr;
  logic [NP-1:0]    lkp_valid_q;
  logic [NP-1:0]    lkp_hit;
  logic [NP-1:0]    lkp_exec;
  logic [NP-1:0]    lkp_cached;
  logic [NP-1:0]    lkp_nonidem;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pma_region_table #(
    .NrRegions    (NR),
    .AddrWidth    (AW),
    .NrLookupPorts(NP),
    .RstBase      ({64'h8000_0000, 64'h0001_0000, 64'h0}),
    .RstLength    ({64'h4000_0000, 64'h0001_0000, 64'h1000}),
    .RstAttr      ({5'h0B, 5'h09, 5'h09})
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .cfg_req_i    (cfg_req),
    .cfg_we_i     (cfg_we),
    .cfg_idx_i    (cfg_idx),
    .cfg_field_i  (cfg_field),
    .cfg_wdata_i  (cfg_wdata),
    .cfg_gnt_o    (cfg_gnt),
    .cfg_rvalid_o (cfg_rvalid),
    .cfg_rdata_o  (cfg_rdata),
    .cfg_err_o    (cfg_err),
    .cfg_change_o (cfg_change),
    .lkp_valid_i  (lkp_valid),
    .lkp_addr_i   (lkp_addr),
    .lkp_valid_o  (lkp_valid_q),
    .lkp_hit_o    (lkp_hit),
    .lkp_exec_o   (lkp_exec),
    .lkp_cached_o (lkp_cached),
    .lkp_nonidem_o(lkp_nonidem)
  );

  task automatic chk(input string tag, input logic [AW-1:0] obs, input logic [AW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic cfg(input logic we, input logic [1:0] idx, input logic [1:0] field,
                     input logic [AW-1:0] wd);
    cfg_req   = 1'b1;
    cfg_we    = we;
    cfg_idx   = idx;
    cfg_field = field;
    cfg_wdata = wd;
  endtask

  task automatic idle;
    cfg_req   = 1'b0;
    cfg_we    = 1'b0;
    lkp_valid = '0;
  endtask

  task automatic lk(input int p, input logic [AW-1:0] a);
    lkp_valid[p]          = 1'b1;
    lkp_addr[p*AW +: AW]  = a;
  endtask

  // Packed {valid, hit, exec, cached, nonidem} of one port.
  task automatic chk_lkp(input string tag, input int p, input logic [4:0] exp);
    chk(tag, AW'({lkp_valid_q[p], lkp_hit[p], lkp_exec[p], lkp_cached[p], lkp_nonidem[p]}),
        AW'(exp));
  endtask

  // Packed {rvalid, err, change}.
  task automatic chk_rsp(input string tag, input logic [2:0] exp);
    chk(tag, AW'({cfg_rvalid, cfg_err, cfg_change}), AW'(exp));
  endtask

  logic [AW-1:0] bnd_addr [4];
  logic          bnd_hit  [4];

  initial begin
    bnd_addr = '{64'hFFF, 64'h1000, 64'h10FF, 64'h1100};
    bnd_hit  = '{1'b0, 1'b1, 1'b1, 1'b0};
    rst = 1'b1;
    cfg_idx = '0; cfg_field = '0; cfg_wdata = '0; lkp_addr = '0;
    idle();
    tick(); tick();

    // reset state
    chk_rsp("rst_rsp", 3'b000);
    chk("rst_rdata", cfg_rdata, '0);
    chk("rst_lkp_valid", AW'(lkp_valid_q), '0);
    chk("rst_lkp_attr", AW'({lkp_hit, lkp_exec, lkp_cached, lkp_nonidem}), AW'(8'b00_00_00_11));
    rst = 1'b0;

    // reset image lookups
    lk(0, 64'h8000_1234); tick(); idle();
    chk_lkp("dflt_hit", 0, 5'b1_1110);
    lk(0, 64'hC000_0000); tick(); idle();
    chk_lkp("dflt_miss", 0, 5'b1_0001);
    tick();
    chk_lkp("idle_hold", 0, 5'b0_0001);
    cfg(1'b0, 2'd2, 2'd2, '0);
    chk("gnt_hi", AW'(cfg_gnt), AW'(1));
    tick(); idle();
    chk_rsp("rd_attr2_rsp", 3'b100);
    chk("rd_attr2", cfg_rdata, 64'h0B);
    chk("gnt_lo", AW'(cfg_gnt), AW'(0));

    // range boundary on entry 0: base 0x1000, length 0x100
    cfg(1'b1, 2'd0, 2'd0, 64'h1000); tick();
    chk_rsp("wr_base_rsp", 3'b101);
    cfg(1'b1, 2'd0, 2'd1, 64'h100); tick(); idle();
    for (int k = 0; k < 4; k++) begin
      lk(0, bnd_addr[k]); tick(); idle();
      chk_lkp($sformatf("bnd_%0h", bnd_addr[k]), 0,
              {1'b1, bnd_hit[k], bnd_hit[k], 1'b0, !bnd_hit[k]});
    end
    cfg(1'b1, 2'd0, 2'd0, 64'hFFFF_FFFF_FFFF_FFF0); tick();
    cfg(1'b1, 2'd0, 2'd1, 64'h20); tick(); idle();
    lk(0, 64'h0); tick(); idle();
    chk_lkp("nowrap_miss", 0, 5'b1_0001);
    lk(0, 64'hFFFF_FFFF_FFFF_FFFF); tick(); idle();
    chk_lkp("top_hit", 0, 5'b1_1100);

    // write/lookup ordering on entry 1
    cfg(1'b1, 2'd1, 2'd2, 64'h08); lk(0, 64'h1_0000); tick();
    chk_lkp("ord_old", 0, 5'b1_1100);
    chk_rsp("ord_chg_n1", 3'b101);
    cfg_req = 1'b0; tick(); idle();
    chk_lkp("ord_new", 0, 5'b1_1000);
    chk_rsp("ord_chg_n2", 3'b000);

    // lock entry 1
    cfg(1'b1, 2'd1, 2'd2, 64'h19); tick();
    chk_rsp("lock_wr", 3'b101);
    cfg(1'b1, 2'd1, 2'd0, 64'hDEAD_0000); tick();
    chk_rsp("lock_base_err", 3'b110);
    cfg(1'b1, 2'd1, 2'd2, 64'h08); tick();
    chk_rsp("lock_attr_err", 3'b110);
    cfg(1'b0, 2'd1, 2'd0, '0); tick();
    chk_rsp("lock_rd_base_rsp", 3'b100);
    chk("lock_rd_base", cfg_rdata, 64'h1_0000);
    cfg(1'b0, 2'd1, 2'd2, '0); tick(); idle();
    chk_rsp("lock_rd_attr_rsp", 3'b100);
    chk("lock_rd_attr", cfg_rdata, 64'h19);

    // reset with a request in flight: no response, table restored
    rst = 1'b1;
    cfg(1'b0, 2'd1, 2'd2, '0); tick();
    chk_rsp("rst_mid_rsp", 3'b000);
    rst = 1'b0; idle(); tick();
    chk_rsp("rst_mid_drop", 3'b000);
    cfg(1'b0, 2'd1, 2'd2, '0); tick();
    chk("unlock_attr", cfg_rdata, 64'h09);
    cfg(1'b0, 2'd0, 2'd1, '0); tick(); idle();
    chk("rst_len0", cfg_rdata, 64'h1000);

    // overlapping entries 0 and 1, back-to-back writes
    cfg(1'b1, 2'd1, 2'd0, 64'h0); tick();
    cfg(1'b1, 2'd1, 2'd1, 64'h2000); tick();
    cfg(1'b1, 2'd1, 2'd2, 64'h0B); tick(); idle();
    chk_rsp("ovl_wr", 3'b101);
    lk(0, 64'h800); lk(1, 64'h1800); tick(); idle();
    chk_lkp("prio_p0", 0, 5'b1_1100);
    chk_lkp("prio_p1", 1, 5'b1_1110);
    lk(0, 64'h8000_1234); lk(1, 64'hC000_0000); tick(); idle();
    chk_lkp("dual_p0", 0, 5'b1_1110);
    chk_lkp("dual_p1", 1, 5'b1_0001);

    // illegal accesses
    cfg(1'b1, 2'd0, 2'd3, 64'h5); tick();
    chk_rsp("ill_field_wr", 3'b110);
    cfg(1'b1, 2'd3, 2'd0, 64'h5); tick();
    chk_rsp("ill_idx_wr", 3'b110);
    cfg(1'b0, 2'd3, 2'd0, '0); tick();
    chk_rsp("ill_idx_rd", 3'b110);
    chk("ill_idx_rdata", cfg_rdata, '0);
    cfg(1'b0, 2'd0, 2'd0, '0); tick(); idle();
    chk("ill_no_update", cfg_rdata, 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pma_region_table.md
# pma_region_table

Runtime-programmable physical-memory-attribute table for the CVA6 core. It generalises the fixed per-build execute, cached and non-idempotent region rules into NrRegions writable entries, and answers NrLookupPorts registered attribute lookups per cycle. It sits between the CSR file (configuration port) and the frontend/LSU (lookup ports). Entries reset to parameter-supplied values, so a build that never writes the table behaves like a static configuration.

## Interface
Parameters:
- NrRegions, 4: number of table entries (1..16).
- AddrWidth, 64: physical address width.
- NrLookupPorts, 2: independent lookup ports (fetch, LSU).
- RstBase, '0: packed NrRegions*AddrWidth reset base addresses; entry i occupies slice i.
- RstLength, '0: packed NrRegions*AddrWidth reset lengths.
- RstAttr, '0: packed NrRegions*5 reset attributes; entry i is {L,V,NI,C,X}.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset; synchronous, active-high.
- cfg_req_i  in  1  configuration access request.
- cfg_we_i  in  1  1 = write, 0 = read.
- cfg_idx_i  in  $clog2(NrRegions) (min 1)  entry index.
- cfg_field_i  in  2  0 = base, 1 = length, 2 = attr; 3 is reserved.
- cfg_wdata_i  in  AddrWidth  write data; attr uses bits [4:0].
- cfg_gnt_o  out  1  request accepted (combinational, always equal to cfg_req_i).
- cfg_rvalid_o  out  1  response valid, one cycle after grant.
- cfg_rdata_o  out  AddrWidth  read data; attr is zero-extended.
- cfg_err_o  out  1  error, qualified by cfg_rvalid_o.
- cfg_change_o  out  1  one-cycle pulse after any successful write.
- lkp_valid_i  in  NrLookupPorts  lookup request per port.
- lkp_addr_i  in  NrLookupPorts*AddrWidth  lookup addresses.
- lkp_valid_o  out  NrLookupPorts  registered response valid.
- lkp_hit_o  out  NrLookupPorts  an enabled region matched.
- lkp_exec_o / lkp_cached_o / lkp_nonidem_o  out  NrLookupPorts each  resolved attributes.

## Operation
- Each entry holds base[AddrWidth], length[AddrWidth], X, C, NI, V and L.
- Entry i matches address a when all of the following hold:
  - V = 1;
  - length != 0;
  - a >= base;
  - (a − base) < length, computed in AddrWidth+1 bits so the comparison never wraps.
- Priority: the lowest matching index wins. Overlapping regions are legal.
- No match gives hit = 0, exec = 0, cached = 0, nonidem = 1 (safe default).
- Config write, when granted:
  - Error, no update and no change pulse if the entry is locked (L = 1 in the current attr), cfg_field_i = 3, or cfg_idx_i >= NrRegions.
  - Otherwise the target field is updated at the next clock edge.
  - Writing attr with L = 1 locks the entry. Only reset clears L.
  - A locked entry's attr can never be rewritten, including rewriting L itself.
- Config read: returns the field's value as it was before the current-cycle edge. Reads error under the same idx/field rules; they never error on lock.
- Each lookup port is independent and has no backpressure. A port with lkp_valid_i = 0 produces lkp_valid_o = 0 next cycle; its other outputs hold their last values.

## Timing
- Reset (rst_i high at a rising edge) loads:
  - entries from RstBase, RstLength and RstAttr;
  - cfg_rvalid_o = 0, cfg_err_o = 0, cfg_rdata_o = 0, cfg_change_o = 0;
  - lkp_valid_o = 0, lkp_hit_o = 0, lkp_exec_o = 0, lkp_cached_o = 0, lkp_nonidem_o = 1.
- Reset mid-transaction drops the pending response. No rvalid follows a request granted in the reset cycle.
- Config: request in cycle N gives cfg_rvalid_o, cfg_err_o and cfg_rdata_o in cycle N+1. Back-to-back requests are accepted every cycle.
- Write in cycle N:
  - the table is updated at the end of N;
  - cfg_change_o is high in N+1;
  - lookups issued in N see the old value;
  - lookups issued in N+1 see the new value.
- Lookup latency is exactly 1 cycle: inputs sampled at edge N are visible on outputs in N+1. Throughput is one lookup per port per cycle.
- Timing path: the match compare for all regions runs in parallel, followed by a priority select. There is no multi-cycle path.

## Test plan
- **Reset defaults:** NrRegions = 3, RstBase = {0x8000_0000, 0x1_0000, 0x0}, RstLength = {0x4000_0000, 0x1_0000, 0x1000}, RstAttr X = 1 on all, C = 1 on entry 2 only (base 0x8000_0000), V = 1 on all. Lookup 0x8000_1234 -> hit = 1, exec = 1, cached = 1, nonidem = 0, one cycle later. Lookup 0xC000_0000 -> hit = 0, nonidem = 1.
- **Range boundary:** entry base 0x1000, length 0x100. Lookups at 0xFFF, 0x1000, 0x10FF and 0x1100 -> hit = 0, 1, 1, 0. Set base = 2^64 − 0x10 and length = 0x20; a lookup at 0x0 -> miss (no wrap).
- **Write/lookup ordering:** write entry 1 attr = 0x08 (V = 1) in cycle N, with a lookup in the region in N and again in N+1 -> the N response shows the old attributes, the N+1 response shows the new ones, and cfg_change_o is high exactly in N+1.
- **Lock:** write attr 0x19 (L = 1, V = 1, X = 1), then write base -> cfg_err_o = 1, base unchanged, no change pulse. Read attr -> 0x19, err = 0. Assert rst_i -> L cleared and RstAttr restored.
- **Priority and illegal accesses:** entries 0 and 1 overlap, with entry 0 C = 0 and entry 1 C = 1; a lookup in the overlap -> cached = 0. A write with field = 3 or idx = NrRegions -> err = 1. Issue two lookup ports concurrently with different addresses -> independent correct responses.
